// File: rtl/hc595_ctrl_if.sv
// hc595_ctrl_if: connection between the segment driver, hc595_ctrl and the two cascaded 74HC595s.
//   sel[5:0]    digit select from the segment driver, bit i = digit i, active high
//   seg[7:0]    segment code from the segment driver, active low, seg[7] = dp
//   ds          595 serial data
//   shcp        595 shift clock, sampled by the 595 on its rising edge
//   stcp        595 storage latch clock, latched by the 595 on its rising edge
//   oe          595 output enable, active low
//   frame_done  one-cycle pulse on the last cycle of each frame
// The master modport is the serialiser side. The slave modport is the driver/board side.
interface hc595_ctrl_if;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       ds;
  logic       shcp;
  logic       stcp;
  logic       oe;
  logic       frame_done;

  modport master (
    input  sel,
    input  seg,
    output ds,
    output shcp,
    output stcp,
    output oe,
    output frame_done
  );

  modport slave (
    output sel,
    output seg,
    input  ds,
    input  shcp,
    input  stcp,
    input  oe,
    input  frame_done
  );
endinterface

// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serialises a snapshot of {seg, sel} into two cascaded 74HC595s, frame after frame.
//   sys_clk    system clock
//   sys_rst_n  asynchronous reset, active low
//   bus        hc595_ctrl_if master: sel/seg in; ds/shcp/stcp/oe/frame_done out (all registered)
// A frame is 1 LOAD cycle, then 14 shift slots, then 1 latch slot. Each slot is DIV_MAX+1 cycles.
// Bit order: sel[0]..sel[5], then seg[7]..seg[0].
// Pins are registered from the current state, so pin timing trails the FSM by one cycle.
// This lag is uniform, so the slot shapes and the frame period are unchanged.
module hc595_ctrl #(
  parameter int unsigned DIV_MAX = 3  // odd, >= 1
) (
  input logic          sys_clk,
  input logic          sys_rst_n,
  hc595_ctrl_if.master bus
);

  localparam int unsigned NBITS = 14;
  localparam int unsigned DivW  = $clog2(DIV_MAX + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(DIV_MAX);
  localparam logic [DivW-1:0] DivHalf = DivW'((DIV_MAX + 1) / 2);
  localparam logic [3:0]      BitLast = 4'(NBITS - 1);

  typedef enum logic [1:0] {StLoad, StShift, StLatch} state_e;

  state_e          state_q;
  logic [DivW-1:0] div_cnt_q;
  logic [3:0]      bit_cnt_q;
  logic [13:0]     shadow_q;  // {seg, sel}
  logic            ds_q;
  logic            shcp_q;
  logic            stcp_q;
  logic            oe_q;
  logic            frame_done_q;

  logic [3:0] bit_idx;
  logic       div_wrap;

  // Slots 0..5 take sel[k] (shadow[k]). Slots 6..13 take seg[13-k], which is shadow[19-k].
  always_comb begin
    bit_idx  = (bit_cnt_q < 4'd6) ? bit_cnt_q : 4'(5'd19 - {1'b0, bit_cnt_q});
    div_wrap = (div_cnt_q == DivLast);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StLoad;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shadow_q     <= '0;
      ds_q         <= 1'b0;
      shcp_q       <= 1'b0;
      stcp_q       <= 1'b0;
      oe_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // Outputs stay disabled until the first complete frame has been latched.
      if (frame_done_q) begin
        oe_q <= 1'b0;
      end
      unique case (state_q)
        StLoad: begin
          shadow_q  <= {bus.seg, bus.sel};
          div_cnt_q <= '0;
          bit_cnt_q <= '0;
          shcp_q    <= 1'b0;
          stcp_q    <= 1'b0;
          state_q   <= StShift;
        end
        StShift: begin
          ds_q   <= shadow_q[bit_idx];
          shcp_q <= (div_cnt_q >= DivHalf);
          stcp_q <= 1'b0;
          if (div_wrap) begin
            div_cnt_q <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == BitLast) begin
              state_q <= StLatch;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        StLatch: begin
          // ds is not assigned here, so it keeps the last bit.
          shcp_q <= 1'b0;
          stcp_q <= 1'b1;
          if (div_wrap) begin
            div_cnt_q    <= '0;
            frame_done_q <= 1'b1;
            state_q      <= StLoad;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

  assign bus.ds         = ds_q;
  assign bus.shcp       = shcp_q;
  assign bus.stcp       = stcp_q;
  assign bus.oe         = oe_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_hc595_ctrl.sv
// tb_hc595_ctrl: drives hc595_ctrl at DIV_MAX=3 (inst 0) and DIV_MAX=1 (inst 1).
// A pin-level frame model checks every output of both instances on every falling edge.
// A two-595 chain model, fed from the DUT pins, pins literal expectations.
module tb_hc595_ctrl;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;

  always #5 sys_clk = ~sys_clk;

  hc595_ctrl_if bus0 ();
  hc595_ctrl_if bus1 ();

  hc595_ctrl #(.DIV_MAX(3)) dut0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus0)
  );

  hc595_ctrl #(.DIV_MAX(1)) dut1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus1)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0] a_ds, a_sh, a_st, a_oe, a_fd;
  assign a_ds = {bus1.ds, bus0.ds};
  assign a_sh = {bus1.shcp, bus0.shcp};
  assign a_st = {bus1.stcp, bus0.stcp};
  assign a_oe = {bus1.oe, bus0.oe};
  assign a_fd = {bus1.frame_done, bus0.frame_done};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [13:0] s, input int k);
    logic [5:0] sl;
    logic [7:0] sg;
    sl = s[5:0];
    sg = s[13:6];
    if (k < 6) return sl[k];
    return sg[13 - k];
  endfunction

  function automatic logic [5:0] rev6(input logic [5:0] v);
    logic [5:0] r;
    for (int b = 0; b < 6; b++) r[b] = v[5 - b];
    return r;
  endfunction

  // ---------------- frame model ----------------
  int          p [2];    // pin frame cycle 1..L, 0 = in reset / not started
  logic [13:0] pend [2];
  logic [13:0] shad [2];
  logic        e_ds [2];
  logic        e_fd [2];
  logic        e_oe [2];
  logic        prev_rst = 1'b0;
  int          s_len, f_len, q;
  logic        e_sh, e_st;

  // ---------------- 595 chain monitor ----------------
  logic [15:0] chain [2];
  logic [13:0] ev [2];
  logic [13:0] last_ev [2];
  logic [5:0]  lat_sel [2];
  logic [7:0]  lat_seg [2];
  int          edges [2];
  int          latches [2];
  int          last_fd [2];
  logic        prev_sh [2];
  logic        prev_st [2];
  int          cyc = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      p[i] = 0; pend[i] = '0; shad[i] = '0; e_ds[i] = 1'b0; e_fd[i] = 1'b0; e_oe[i] = 1'b1;
      chain[i] = '0; ev[i] = '0; last_ev[i] = '0; lat_sel[i] = '0; lat_seg[i] = '0;
      edges[i] = 0; latches[i] = 0; last_fd[i] = -1; prev_sh[i] = 1'b0; prev_st[i] = 1'b0;
    end
    forever begin
      @(negedge sys_clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        s_len = (i == 0) ? 4 : 2;
        f_len = 1 + 15 * s_len;
        if (!sys_rst_n) begin
          p[i] = 0; e_ds[i] = 1'b0; e_fd[i] = 1'b0; e_oe[i] = 1'b1;
        end else if (prev_rst) begin
          if (e_fd[i]) e_oe[i] = 1'b0;
          if (p[i] == 0 || p[i] == f_len) begin
            p[i] = 1;
            shad[i] = pend[i];
          end else begin
            p[i]++;
          end
          e_fd[i] = (p[i] == f_len);
        end
        e_sh = 1'b0;
        e_st = 1'b0;
        if (p[i] >= 2 && p[i] <= 1 + 14 * s_len) begin
          q = p[i] - 2;
          e_ds[i] = bit_of(shad[i], q / s_len);
          e_sh = ((q % s_len) >= s_len / 2);
        end else if (p[i] > 1 + 14 * s_len) begin
          e_st = 1'b1;
        end
        check($sformatf("inst%0d ds p=%0d", i, p[i]), 32'(a_ds[i]), 32'(e_ds[i]));
        check($sformatf("inst%0d shcp p=%0d", i, p[i]), 32'(a_sh[i]), 32'(e_sh));
        check($sformatf("inst%0d stcp p=%0d", i, p[i]), 32'(a_st[i]), 32'(e_st));
        check($sformatf("inst%0d oe p=%0d", i, p[i]), 32'(a_oe[i]), 32'(e_oe[i]));
        check($sformatf("inst%0d frame_done p=%0d", i, p[i]), 32'(a_fd[i]), 32'(e_fd[i]));
        pend[i] = (i == 0) ? {bus0.seg, bus0.sel} : {bus1.seg, bus1.sel};

        // Chain monitor, driven purely by the pins.
        if (!sys_rst_n) begin
          edges[i] = 0;
          ev[i] = '0;
          last_fd[i] = -1;
        end
        if (a_sh[i] && !prev_sh[i]) begin
          chain[i] = {chain[i][14:0], a_ds[i]};
          ev[i] = {ev[i][12:0], a_ds[i]};
          edges[i]++;
        end
        if (a_st[i] && !prev_st[i]) begin
          check($sformatf("inst%0d shcp_edges_per_frame", i), 32'(edges[i]), 32'd14);
          lat_seg[i] = chain[i][7:0];
          lat_sel[i] = rev6(chain[i][13:8]);
          last_ev[i] = ev[i];
          edges[i] = 0;
          latches[i]++;
        end
        if (a_fd[i]) begin
          if (last_fd[i] >= 0)
            check($sformatf("inst%0d frame_done_period", i), 32'(cyc - last_fd[i]),
                  (i == 0) ? 32'd61 : 32'd31);
          last_fd[i] = cyc;
        end
        prev_sh[i] = a_sh[i];
        prev_st[i] = a_st[i];
      end
      prev_rst = sys_rst_n;
    end
  end

  // Waits for frame_done of instance i; leaves the caller 2 time units after that edge.
  task automatic wait_fd(input int i, input int budget);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge sys_clk);
      #2;
      seen = (i == 0) ? bus0.frame_done : bus1.frame_done;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_frame_done inst%0d: no pulse within %0d cycles", i, budget);
    end
  endtask

  int lat_before;

  initial begin
    bus0.sel = 6'h3F;
    bus0.seg = 8'hC0;
    bus1.sel = 6'h01;
    bus1.seg = 8'h80;
    #1 sys_rst_n = 1'b0;
    repeat (5) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;

    // DIV_MAX=1 instance: 31-cycle frame, stream 1,0,0,0,0,0,1,0,0,0,0,0,0,0.
    wait_fd(1, 100);
    check("inst1 stream", 32'(last_ev[1]), 32'(14'b10000010000000));
    check("inst1 latched_sel", 32'(lat_sel[1]), 32'h01);
    check("inst1 latched_seg", 32'(lat_seg[1]), 32'h80);

    // Basic frame at DIV_MAX=3.
    wait_fd(0, 100);
    check("frame1 stream", 32'(last_ev[0]), 32'(14'b11111111000000));
    check("frame1 latched_sel", 32'(lat_sel[0]), 32'h3F);
    check("frame1 latched_seg", 32'(lat_seg[0]), 32'hC0);
    check("oe at first frame_done", 32'(bus0.oe), 32'd1);
    @(posedge sys_clk);
    #2;
    check("oe after first frame_done", 32'(bus0.oe), 32'd0);

    // Now at pin cycle 1 of frame 2; slot 4 starts at pin cycle 18.
    repeat (17) @(posedge sys_clk);
    #2 bus0.seg = 8'hF9;
    wait_fd(0, 100);
    check("frame2 latched_seg", 32'(lat_seg[0]), 32'hC0);
    check("frame2 latched_sel", 32'(lat_sel[0]), 32'h3F);
    wait_fd(0, 100);
    check("frame3 latched_seg", 32'(lat_seg[0]), 32'hF9);
    check("frame3 tail bits", 32'(last_ev[0][7:0]), 32'(8'b11111001));
    check("frame3 oe", 32'(bus0.oe), 32'd0);

    // Reset at frame 4 slot 9 (pin cycle 38) for 3 cycles.
    repeat (38) @(posedge sys_clk);
    #2;
    lat_before = latches[0];
    sys_rst_n = 1'b0;
    #1;
    check("async reset shcp", 32'(bus0.shcp), 32'd0);
    check("async reset oe", 32'(bus0.oe), 32'd1);
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    check("no stcp on aborted frame", 32'(latches[0]), 32'(lat_before));
    wait_fd(0, 100);
    check("frame after reset latched", 32'(latches[0]), 32'(lat_before + 1));
    check("frame after reset seg", 32'(lat_seg[0]), 32'hF9);

    // Randomised input changes and occasional resets, checked by the frame model.
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 120)) @(posedge sys_clk);
      #2;
      bus0.sel = 6'($urandom);
      bus0.seg = 8'($urandom);
      bus1.sel = 6'($urandom);
      bus1.seg = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        sys_rst_n = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
      end
    end
    wait_fd(0, 200);
    repeat (3) @(posedge sys_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
